// File: rtl/snake_pkg.sv
// Shared snake game definitions: grid geometry, cell layout, direction and
// state encodings. Also imported by the display block.
package snake_pkg;

    localparam int unsigned GRID_ROWS = 16;
    localparam int unsigned GRID_COLS = 16;
    localparam int unsigned MAX_LEN   = 16;
    localparam int unsigned ROW_W     = 4;
    localparam int unsigned COL_W     = 4;
    localparam int unsigned CELL_W    = ROW_W + COL_W;
    localparam int unsigned LEN_W     = 4;
    localparam int unsigned FLAT_W    = MAX_LEN * CELL_W;
    localparam int unsigned STATE_W   = 5;

    // One grid cell: row in the upper nibble, column in the lower nibble.
    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } cell_t;

    // Opposite directions differ only in bit 0.
    typedef enum logic [1:0] {
        DIR_U = 2'd0,
        DIR_D = 2'd1,
        DIR_L = 2'd2,
        DIR_R = 2'd3
    } dir_e;

    // One-hot so each status flag is a flop output.
    typedef enum logic [STATE_W-1:0] {
        ST_QI = 5'b00001,
        ST_QP = 5'b00010,
        ST_QC = 5'b00100,
        ST_QW = 5'b01000,
        ST_QL = 5'b10000
    } state_e;

    function automatic dir_e dir_opposite(input dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_hit_detect.sv
// Combinational cell-vs-body compare.
// Ports: cell_i  - cell under test
//        segs_i  - all segment cells (index 0 = head)
//        mask_i  - which segments take part in the compare
//        hit_c_o - cell matches at least one masked segment
module snake_hit_detect
    import snake_pkg::*;
(
    input  cell_t               cell_i,
    input  cell_t [MAX_LEN-1:0] segs_i,
    input  logic  [MAX_LEN-1:0] mask_i,
    output logic                hit_c_o
);

    always_comb begin
        hit_c_o = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (mask_i[i] && (segs_i[i] == cell_i)) hit_c_o = 1'b1;
        end
    end

endmodule

// File: rtl/snake_engine.sv
// Snake game engine on a 16x16 grid: movement, growth, food placement and
// win/lose detection.
// Ports: Clk, Reset (sync, active high), Tick (move strobe), Start,
//        BtnU/BtnD/BtnL/BtnR (direction requests), Rand (food candidate),
//        Qi/Qp/Qc/Qw/Ql (one-hot state), Length (segments minus one),
//        Food (food cell), Locations_Flat (segment 0 in [127:120]).
// Build option: define SNAKE_WRAP_EN to make the grid edges wrap instead of
// being walls.
module snake_engine
    import snake_pkg::*;
#(
    parameter logic [7:0] START_LOC = 8'h88,
    parameter logic [7:0] INIT_FOOD = 8'h8C
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Tick,
    input  logic              Start,
    input  logic              BtnU,
    input  logic              BtnD,
    input  logic              BtnL,
    input  logic              BtnR,
    input  logic [CELL_W-1:0] Rand,
    output logic              Qi,
    output logic              Qp,
    output logic              Qc,
    output logic              Qw,
    output logic              Ql,
    output logic [LEN_W-1:0]  Length,
    output logic [CELL_W-1:0] Food,
    output logic [FLAT_W-1:0] Locations_Flat
);

`ifdef SNAKE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    state_e               state_q, state_d;
    cell_t  [MAX_LEN-1:0] segs_q, segs_d;
    logic   [LEN_W-1:0]   len_q, len_d;
    cell_t                food_q, food_d;
    dir_e                 dir_q, dir_d;
    dir_e                 pend_q, pend_d;

    cell_t                head_c, next_head_c;
    cell_t  [MAX_LEN-1:0] shift_c;
    logic   [MAX_LEN-1:0] self_mask_c, body_mask_c;
    logic                 edge_c, wall_c, eat_c, self_hit_c, rand_taken_c;
    logic                 btn_req_c;
    dir_e                 btn_dir_c;
    logic   [STATE_W-1:0] state_bits_c;

    assign head_c = segs_q[0];
    assign eat_c  = (next_head_c == food_q);
    assign wall_c = edge_c & ~WRAP_EN;

    // Candidate head one step in the pending direction; 4-bit arithmetic wraps.
    always_comb begin
        next_head_c = head_c;
        edge_c      = 1'b0;
        case (pend_q)
            DIR_U: begin
                next_head_c.row = head_c.row - 4'd1;
                edge_c          = (head_c.row == '0);
            end
            DIR_D: begin
                next_head_c.row = head_c.row + 4'd1;
                edge_c          = (head_c.row == ROW_W'(GRID_ROWS - 1));
            end
            DIR_L: begin
                next_head_c.col = head_c.col - 4'd1;
                edge_c          = (head_c.col == '0);
            end
            DIR_R: begin
                next_head_c.col = head_c.col + 4'd1;
                edge_c          = (head_c.col == COL_W'(GRID_COLS - 1));
            end
        endcase
    end

    // Tail only blocks the head when the move eats, since otherwise it vacates.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            body_mask_c[i] = (LEN_W'(i) <= len_q);
            self_mask_c[i] = (i != 0) &&
                             ((LEN_W'(i) < len_q) || ((LEN_W'(i) == len_q) && eat_c));
        end
    end

    snake_hit_detect u_self_hit (
        .cell_i  (next_head_c),
        .segs_i  (segs_q),
        .mask_i  (self_mask_c),
        .hit_c_o (self_hit_c)
    );

    snake_hit_detect u_food_free (
        .cell_i  (cell_t'(Rand)),
        .segs_i  (segs_q),
        .mask_i  (body_mask_c),
        .hit_c_o (rand_taken_c)
    );

    // Body after a move: new head in front, everything else one slot back.
    always_comb begin
        shift_c[0] = next_head_c;
        for (int i = 1; i < MAX_LEN; i++) shift_c[i] = segs_q[i-1];
    end

    // Button priority U > D > L > R; an immediate reversal is dropped once the body exists.
    always_comb begin
        btn_req_c = 1'b1;
        btn_dir_c = DIR_R;
        if (BtnU)      btn_dir_c = DIR_U;
        else if (BtnD) btn_dir_c = DIR_D;
        else if (BtnL) btn_dir_c = DIR_L;
        else if (BtnR) btn_dir_c = DIR_R;
        else           btn_req_c = 1'b0;
        if ((len_q != '0) && (btn_dir_c == dir_opposite(dir_q))) btn_req_c = 1'b0;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        segs_d  = segs_q;
        len_d   = len_q;
        food_d  = food_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        case (state_q)
            ST_QI: begin
                if (Start) state_d = ST_QP;
            end
            ST_QP: begin
                if (Tick) begin
                    if (wall_c || self_hit_c) begin
                        state_d = ST_QL;
                    end else begin
                        dir_d = pend_q;
                        len_d = eat_c ? (len_q + 4'd1) : len_q;
                        // Unused slots replicate the tail so they draw on top of it.
                        for (int i = 0; i < MAX_LEN; i++) begin
                            segs_d[i] = (LEN_W'(i) > len_d) ? shift_c[len_d] : shift_c[i];
                        end
                        if (eat_c) begin
                            state_d = (len_q == LEN_W'(MAX_LEN - 2)) ? ST_QW : ST_QC;
                        end
                    end
                end else if (btn_req_c) begin
                    pend_d = btn_dir_c;
                end
            end
            ST_QC: begin
                if (!rand_taken_c) begin
                    food_d  = cell_t'(Rand);
                    state_d = ST_QP;
                end
            end
            ST_QW, ST_QL: begin
                if (Start) begin
                    state_d = ST_QI;
                    segs_d  = {MAX_LEN{START_LOC}};
                    len_d   = '0;
                    food_d  = cell_t'(INIT_FOOD);
                    dir_d   = DIR_R;
                    pend_d  = DIR_R;
                end
            end
            default: state_d = ST_QI;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_QI;
            segs_q  <= {MAX_LEN{START_LOC}};
            len_q   <= '0;
            food_q  <= cell_t'(INIT_FOOD);
            dir_q   <= DIR_R;
            pend_q  <= DIR_R;
        end else begin
            state_q <= state_d;
            segs_q  <= segs_d;
            len_q   <= len_d;
            food_q  <= food_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
        end
    end

    assign state_bits_c = state_q;
    assign Qi     = state_bits_c[0];
    assign Qp     = state_bits_c[1];
    assign Qc     = state_bits_c[2];
    assign Qw     = state_bits_c[3];
    assign Ql     = state_bits_c[4];
    assign Length = len_q;
    assign Food   = food_q;

    // Head lands in the top byte of the flat bus.
    always_comb begin
        Locations_Flat = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            Locations_Flat[FLAT_W - 1 - i * CELL_W -: CELL_W] = segs_q[i];
        end
    end

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: a queue-based game model predicts every output after
// each clock edge, plus literal expectations at the scenario milestones.
module tb_snake_engine;

    localparam logic [7:0] START = 8'h88;
    localparam logic [7:0] FOOD0 = 8'h8C;
    localparam logic [3:0] B_NONE = 4'b0000;
    localparam logic [3:0] B_U = 4'b1000;
    localparam logic [3:0] B_D = 4'b0100;
    localparam logic [3:0] B_L = 4'b0010;
    localparam logic [3:0] B_R = 4'b0001;
    localparam int M_QI = 0, M_QP = 1, M_QC = 2, M_QW = 3, M_QL = 4;

    logic         Clk, Reset, Tick, Start, BtnU, BtnD, BtnL, BtnR;
    logic [7:0]   Rand;
    logic         Qi, Qp, Qc, Qw, Ql;
    logic [3:0]   Length;
    logic [7:0]   Food;
    logic [127:0] Locations_Flat;

    int checks;
    int failures;

    snake_engine #(.START_LOC(START), .INIT_FOOD(FOOD0)) dut (
        .Clk(Clk), .Reset(Reset), .Tick(Tick), .Start(Start),
        .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR), .Rand(Rand),
        .Qi(Qi), .Qp(Qp), .Qc(Qc), .Qw(Qw), .Ql(Ql),
        .Length(Length), .Food(Food), .Locations_Flat(Locations_Flat)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Game model: body queue holds exactly Length+1 cells, head first.
    int         m_state;
    logic [7:0] m_body[$];
    int         m_len;
    logic [7:0] m_food;
    int         m_dir;
    int         m_pend;

    task automatic model_reinit();
        m_state = M_QI;
        m_body  = {};
        m_body.push_back(START);
        m_len   = 0;
        m_food  = FOOD0;
        m_dir   = 3;
        m_pend  = 3;
    endtask

    task automatic model_move();
        logic [7:0] h;
        logic [7:0] nh;
        int r, c;
        bit hit, eat;
        h = m_body[0];
        r = int'(h[7:4]);
        c = int'(h[3:0]);
        case (m_pend)
            0: r = r - 1;
            1: r = r + 1;
            2: c = c - 1;
            default: c = c + 1;
        endcase
        hit = (r < 0) || (r > 15) || (c < 0) || (c > 15);
`ifdef SNAKE_WRAP_EN
        hit = 1'b0;
        r = (r + 16) % 16;
        c = (c + 16) % 16;
`endif
        if (hit) begin
            m_state = M_QL;
            return;
        end
        nh  = 8'(r * 16 + c);
        eat = (nh == m_food);
        for (int k = 1; k <= m_len; k++) begin
            if ((k < m_len || eat) && m_body[k] == nh) hit = 1'b1;
        end
        if (hit) begin
            m_state = M_QL;
            return;
        end
        m_dir = m_pend;
        m_body.push_front(nh);
        if (eat) begin
            m_len   = m_len + 1;
            m_state = (m_len == 15) ? M_QW : M_QC;
        end else begin
            void'(m_body.pop_back());
        end
    endtask

    task automatic model_step(input logic rs, tk, st, input logic [3:0] btn, input logic [7:0] rn);
        int want;
        bit free;
        if (rs) begin
            model_reinit();
            return;
        end
        case (m_state)
            M_QI: if (st) m_state = M_QP;
            M_QP: begin
                if (tk) begin
                    model_move();
                end else begin
                    want = -1;
                    if (btn[3])      want = 0;
                    else if (btn[2]) want = 1;
                    else if (btn[1]) want = 2;
                    else if (btn[0]) want = 3;
                    if (want >= 0 && !(m_len > 0 && want == (m_dir ^ 1))) m_pend = want;
                end
            end
            M_QC: begin
                free = 1'b1;
                for (int k = 0; k <= m_len; k++) if (m_body[k] == rn) free = 1'b0;
                if (free) begin
                    m_food  = rn;
                    m_state = M_QP;
                end
            end
            default: if (st) model_reinit();
        endcase
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle, advance the model, then compare after the edge.
    task automatic cyc(input logic rs, tk, st, input logic [3:0] btn, input logic [7:0] rn);
        logic [127:0] exp_flat;
        logic [4:0]   exp_flags;
        Reset = rs; Tick = tk; Start = st;
        {BtnU, BtnD, BtnL, BtnR} = btn;
        Rand = rn;
        model_step(rs, tk, st, btn, rn);
        @(posedge Clk);
        #1;
        exp_flags = 5'b00001 << m_state;
        exp_flat  = '0;
        for (int i = 0; i < 16; i++) begin
            exp_flat[127 - 8 * i -: 8] = m_body[(i <= m_len) ? i : m_len];
        end
        chk("flags", 128'({Ql, Qw, Qc, Qp, Qi}), 128'(exp_flags));
        chk("length", 128'(Length), 128'(m_len));
        chk("food", 128'(Food), 128'(m_food));
        chk("segments", Locations_Flat, exp_flat);
    endtask

    task automatic tick();
        cyc(1'b0, 1'b1, 1'b0, B_NONE, 8'h00);
    endtask

    task automatic press(input logic [3:0] btn);
        cyc(1'b0, 1'b0, 1'b0, btn, 8'h00);
    endtask

    task automatic start();
        cyc(1'b0, 1'b0, 1'b1, B_NONE, 8'h00);
    endtask

    task automatic offer(input logic [7:0] rn);
        cyc(1'b0, 1'b0, 1'b0, B_NONE, rn);
    endtask

    logic [7:0] tgt [14];

    initial begin
        checks = 0;
        failures = 0;
        Reset = 1'b1; Tick = 1'b0; Start = 1'b0;
        BtnU = 1'b0; BtnD = 1'b0; BtnL = 1'b0; BtnR = 1'b0;
        Rand = 8'h00;
        model_reinit();

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, B_NONE, 8'h00);
        cyc(1'b1, 1'b1, 1'b1, B_U, 8'h00);
        chk("rst_qi", 128'(Qi), 128'(1));
        chk("rst_len", 128'(Length), 128'(0));
        chk("rst_food", 128'(Food), 128'(8'h8C));
        chk("rst_segs", Locations_Flat, {16{8'h88}});

        // Idle ignores Tick/buttons; then three plain moves
        cyc(1'b0, 1'b1, 1'b0, B_D, 8'h00);
        start();
        tick(); press(B_NONE); tick(); tick();
        chk("r036_head", 128'(Locations_Flat[127:120]), 128'(8'h8B));
        chk("r036_qp", 128'(Qp), 128'(1));

        // Eat, then food retry on an occupied cell (Tick ignored meanwhile)
        tick();
        chk("r037_head", 128'(Locations_Flat[127:120]), 128'(8'h8C));
        chk("r037_len", 128'(Length), 128'(1));
        chk("r037_qc", 128'(Qc), 128'(1));
        cyc(1'b0, 1'b1, 1'b0, B_NONE, 8'h8C);
        offer(8'h20);
        chk("r037_food", 128'(Food), 128'(8'h20));
        chk("r037_qp", 128'(Qp), 128'(1));

        // Reversal ignored, Start in play ignored
        press(B_L);
        tick();
        chk("r038_head", 128'(Locations_Flat[127:120]), 128'(8'h8D));
        chk("r038_seg1", 128'(Locations_Flat[119:112]), 128'(8'h8C));
        start();
        tick(); tick();
        tick();
`ifdef SNAKE_WRAP_EN
        chk("r039_head", 128'(Locations_Flat[127:120]), 128'(8'h80));
        chk("r039_qp", 128'(Qp), 128'(1));
`else
        chk("r039_ql", 128'(Ql), 128'(1));
        chk("r039_head", 128'(Locations_Flat[127:120]), 128'(8'h8F));
        chk("r039_seg1", 128'(Locations_Flat[119:112]), 128'(8'h8E));
`endif
        tick();
        start();

        // Coiled body: tail chase is legal, hitting segment 3 is not
        cyc(1'b1, 1'b0, 1'b0, B_NONE, 8'h00);
        start();
        tick(); tick(); tick(); tick();
        offer(8'h8D); tick();
        offer(8'h8E); tick();
        offer(8'h7D);
        press(B_D); tick();
        press(B_L); tick();
        press(B_U); tick();
        chk("r041_tail_qp", 128'(Qp), 128'(1));
        chk("r041_tail_head", 128'(Locations_Flat[127:120]), 128'(8'h8D));
        chk("r041_tail_len", 128'(Length), 128'(3));
        tick();
        chk("r041_len4", 128'(Length), 128'(4));
        offer(8'h20);
        press(B_R); tick();
        press(B_D); tick();
        press(B_L); tick();
        chk("r041_self_ql", 128'(Ql), 128'(1));
        chk("r041_self_head", 128'(Locations_Flat[127:120]), 128'(8'h8E));
        start();
        chk("reinit_ql_qi", 128'(Qi), 128'(1));

        // Grow to full length for the win
        tgt = '{8'h8D, 8'h8E, 8'h8F, 8'h9F, 8'h9E, 8'h9D, 8'h9C,
                8'h9B, 8'h9A, 8'h99, 8'h98, 8'h97, 8'h96, 8'h95};
        start();
        tick(); tick(); tick(); tick();
        for (int k = 0; k < 14; k++) begin
            offer(tgt[k]);
            if (tgt[k] == 8'h9F) press(B_D | B_L);
            if (tgt[k] == 8'h9E) press(B_L | B_R);
            if (k == 13) chk("r040_len14", 128'(Length), 128'(14));
            tick();
        end
        chk("r040_qw", 128'(Qw), 128'(1));
        chk("r040_len15", 128'(Length), 128'(15));
        tick();
        start();
        chk("r040_qi", 128'(Qi), 128'(1));
        chk("r040_len0", 128'(Length), 128'(0));
        chk("r040_food", 128'(Food), 128'(8'h8C));

        // Reset during a food retry
        start();
        tick(); tick(); tick(); tick();
        offer(8'h8C);
        chk("r030_qc", 128'(Qc), 128'(1));
        cyc(1'b1, 1'b0, 1'b0, B_NONE, 8'h20);
        chk("r030_qi", 128'(Qi), 128'(1));
        chk("r030_food", 128'(Food), 128'(8'h8C));
        chk("r030_segs", Locations_Flat, {16{8'h88}});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
